// File: rtl/alu_pkg.sv
// Shared definitions for the Power ALU logic-unit arbiter: opcodes, FSM states, width.
// Optional statistics counters in alu_op_arbiter are enabled with ALU_ARB_STATS_EN.
package alu_pkg;

  localparam int WIDTH = 8;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND   = 3'd0;
  localparam op_t OP_OR    = 3'd1;
  localparam op_t OP_XOR   = 3'd2;
  localparam op_t OP_XNOR  = 3'd3;
  localparam op_t OP_NAND  = 3'd4;
  localparam op_t OP_NOR   = 3'd5;
  localparam op_t OP_NOTA  = 3'd6;
  localparam op_t OP_PASSA = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_logic_8bit.sv
// Combinational bitwise logic unit: op/a/b -> result. No state.
module alu_logic_8bit
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] res_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_AND:   res_o = a_i & b_i;
      OP_OR:    res_o = a_i | b_i;
      OP_XOR:   res_o = a_i ^ b_i;
      OP_XNOR:  res_o = ~(a_i ^ b_i);
      OP_NAND:  res_o = ~(a_i & b_i);
      OP_NOR:   res_o = ~(a_i | b_i);
      OP_NOTA:  res_o = ~a_i;
      OP_PASSA: res_o = a_i;
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_arbiter.sv
// Two-port round-robin arbiter and IDLE/EXEC/RESP sequencer for the shared logic unit.
// Define ALU_ARB_STATS_EN to add saturating per-requester accept counters gnt_cnt0/gnt_cnt1.
module alu_op_arbiter
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_id,
  output logic         res_zero,
`ifdef ALU_ARB_STATS_EN
  output logic [7:0]   gnt_cnt0,
  output logic [7:0]   gnt_cnt1,
`endif
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Requesters hold valid/op/operands until ready (dropping valid withdraws); the result
  // stays stable while res_valid is high and res_ready is low.
  state_t       state_q;
  logic         last_grant_q;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic         id_q;
  logic         res_valid_q, res_id_q, res_zero_q;
  logic [W-1:0] res_data_q;

  logic         gnt0, gnt1, accept;
  logic [2:0]   op_d;
  logic [W-1:0] a_d, b_d, alu_res;
  logic         id_d;

  // Under contention the requester that did not win last time is granted.
  assign gnt0   = req0_valid & (~req1_valid | last_grant_q);
  assign gnt1   = req1_valid & (~req0_valid | ~last_grant_q);
  assign accept = (state_q == ST_IDLE) & (gnt0 | gnt1);

  assign req0_ready = rst_n & (state_q == ST_IDLE) & gnt0;
  assign req1_ready = rst_n & (state_q == ST_IDLE) & gnt1;

  assign id_d = gnt1;
  assign op_d = gnt1 ? req1_op : req0_op;
  assign a_d  = gnt1 ? req1_a  : req0_a;
  assign b_d  = gnt1 ? req1_b  : req0_b;

  alu_logic_8bit #(.W(W)) u_logic (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      res_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_grant_q <= id_d;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_data_q  <= alu_res;
          res_id_q    <= id_q;
          res_zero_q  <= (alu_res == '0);
          res_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_zero  = res_zero_q;
  assign dbg_state = state_q;

`ifdef ALU_ARB_STATS_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else if (accept) begin
      if (!id_d && cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'd1;
      if (id_d && cnt1_q != 8'hFF)  cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Scoreboard bench for alu_op_arbiter: directed scenarios plus randomized two-port traffic.
// Build with ALU_ARB_STATS_EN to also check the grant counters.
module tb_alu_op_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       res_ready = 1'b1;
  logic       req0_ready, req1_ready, res_valid, res_id, res_zero;
  logic [7:0] res_data;
  logic [1:0] dbg_state;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  alu_op_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_zero   (res_zero),
`ifdef ALU_ARB_STATS_EN
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model state ----------------
  int         checks = 0, errors = 0;
  logic [9:0] exp_q[$];      // {zero, id, data}
  logic [9:0] res_log[$];
  int         acc_log[$];
  int         acc_cnt[2] = '{0, 0};
  bit         busy = 1'b0;   // an accepted op has not yet been consumed
  bit         lg = 1'b1;     // last granted requester
  int         acc_cyc = 0, cyc_n = 0;
  int         mcnt0 = 0, mcnt1 = 0;
  bit         prev_v = 1'b0;
  logic [7:0] prev_d;
  logic       prev_id;
  bit         rnd_on = 1'b0;

  function automatic logic [7:0] ref_op(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a ^ b);
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 1'b0;
    lg = 1'b1;
    exp_q.delete();
    prev_v = 1'b0;
    mcnt0 = 0;
    mcnt1 = 0;
  endtask

  // ---------------- monitor: predicts handshakes, pops and compares results ----------------
  always @(negedge clk) begin
    logic e0, e1, ev;
    logic [7:0] d;
    logic [9:0] e;
    if (rst_n) begin
      cyc_n++;
      e0 = !busy && req0_valid && (!req1_valid || lg);
      e1 = !busy && req1_valid && (!req0_valid || !lg);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      ev = busy && (cyc_n >= acc_cyc + 2);
      chk("res_valid", res_valid, ev);
      if (prev_v && res_valid) begin
        chk("hold_data", res_data, prev_d);
        chk("hold_id", res_id, prev_id);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h expected=none", res_data);
        end else begin
          e = exp_q.pop_front();
          chk("result", {res_zero, res_id, res_data}, e);
        end
        res_log.push_back({res_zero, res_id, res_data});
        busy = 1'b0;
      end
      if (e0 || e1) begin
        d = e1 ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
        exp_q.push_back({(d == 8'h00), e1, d});
        busy = 1'b1;
        acc_cyc = cyc_n;
        lg = e1;
        acc_cnt[e1]++;
        acc_log.push_back(cyc_n);
        if (e1) mcnt1 = (mcnt1 < 255) ? mcnt1 + 1 : 255;
        else    mcnt0 = (mcnt0 < 255) ? mcnt0 + 1 : 255;
      end
      prev_v = res_valid && !res_ready;
      prev_d = res_data;
      prev_id = res_id;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; holds the request until the model sees it accepted.
  task automatic issue(int p, logic [2:0] op, logic [7:0] a, logic [7:0] b, bit keep);
    int start = acc_cnt[p];
    int n = 0;
    if (p == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    while (acc_cnt[p] == start && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (acc_cnt[p] == start) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout port=%0d actual=no_accept expected=accept", p);
    end
    if (!keep) begin
      if (p == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (busy || exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=busy expected=idle");
    end
  endtask

  task automatic wait_res_valid();
    int n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_seen", res_valid, 1'b1);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_req0_ready"}, req0_ready, 1'b0);
    chk({tag, "_req1_ready"}, req1_ready, 1'b0);
    chk({tag, "_res_valid"}, res_valid, 1'b0);
    chk({tag, "_res_data"}, res_data, 8'h00);
    chk({tag, "_res_id"}, res_id, 1'b0);
    chk({tag, "_res_zero"}, res_zero, 1'b0);
`ifdef ALU_ARB_STATS_EN
    chk({tag, "_gnt_cnt0"}, gnt_cnt0, 8'h00);
    chk({tag, "_gnt_cnt1"}, gnt_cnt1, 8'h00);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // contention from reset: req0 first, then req1, then req0 again
    res_log.delete();
    fork
      issue(0, OP_AND, 8'hF0, 8'h3C, 1'b0);
      issue(1, OP_XOR, 8'h55, 8'hAA, 1'b0);
    join
    wait_idle();
    fork
      issue(0, OP_AND, 8'hF0, 8'h3C, 1'b0);
      issue(1, OP_XOR, 8'h55, 8'hAA, 1'b0);
    join
    wait_idle();
    chk("contention_n", res_log.size(), 4);
    if (res_log.size() == 4) begin
      chk("contention_0", res_log[0], {1'b0, 1'b0, 8'h30});
      chk("contention_1", res_log[1], {1'b0, 1'b1, 8'hFF});
      chk("contention_2", res_log[2], {1'b0, 1'b0, 8'h30});
      chk("contention_3", res_log[3], {1'b0, 1'b1, 8'hFF});
    end

    // backpressure: result held 10 cycles, a waiting requester stalls
    res_ready = 1'b0;
    issue(0, OP_OR, 8'h12, 8'h34, 1'b0);
    wait_res_valid();
    req1_valid = 1'b1; req1_op = OP_NOR; req1_a = 8'h0F; req1_b = 8'h30;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_res_valid", res_valid, 1'b1);
      chk("bp_res_data", res_data, 8'h36);
      chk("bp_req0_ready", req0_ready, 1'b0);
      chk("bp_req1_ready", req1_ready, 1'b0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", res_valid, 1'b0);
    chk("bp_release_ready1", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();
    chk("bp_req1_result", res_log[res_log.size()-1], {1'b0, 1'b1, 8'hC0});

    // zero flag
    issue(0, OP_XNOR, 8'h00, 8'hFF, 1'b0);
    wait_idle();
    chk("zero_xnor", res_log[res_log.size()-1], {1'b1, 1'b0, 8'h00});
    issue(1, OP_NOTA, 8'h00, 8'h5A, 1'b0);
    wait_idle();
    chk("zero_nota", res_log[res_log.size()-1], {1'b0, 1'b1, 8'hFF});

    // asynchronous reset in RESP discards the in-flight op
    res_ready = 1'b0;
    issue(0, OP_AND, 8'h77, 8'h0F, 1'b0);
    wait_res_valid();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    issue(0, OP_XNOR, 8'hFF, 8'h4A, 1'b0);
    wait_idle();
    chk("post_reset_xnor", res_log[res_log.size()-1], {1'b0, 1'b0, 8'h4A});

    // throughput: back-to-back ops on req0, one accept every 3 cycles
    acc_log.delete();
    for (int i = 0; i < 8; i++) issue(0, 3'(i), 8'h84, 8'h40, 1'b1);
    req0_valid = 1'b0;
    wait_idle();
    chk("thru_accepts", acc_log.size(), 8);
    for (int i = 1; i < acc_log.size(); i++)
      chk("thru_interval", acc_log[i] - acc_log[i-1], 3);

    // randomized two-port traffic with random backpressure
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    fork
      for (int i = 0; i < 40; i++) begin
        issue(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
      end
      for (int i = 0; i < 40; i++) begin
        issue(1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
      end
    join
    rnd_on = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    res_ready = 1'b1;
    wait_idle();
`ifdef ALU_ARB_STATS_EN
    chk("stats_cnt0_model", gnt_cnt0, mcnt0);
    chk("stats_cnt1_model", gnt_cnt1, mcnt1);
`endif

    // 300 accepts on req1 from a fresh reset
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++)
      issue(1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
    wait_idle();
    chk("sat_model_cnt1", mcnt1, 255);
`ifdef ALU_ARB_STATS_EN
    chk("sat_gnt_cnt1", gnt_cnt1, 8'd255);
    chk("sat_gnt_cnt0", gnt_cnt0, 8'd0);
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
